vector_loader: RTL

//   Upstream feeder for the 32-bit dot-product stage. Accepts a byte stream over

---
 rtl/vector_loader_pkg.sv | 16 +
 rtl/vector_loader_if.sv | 44 ++++
 rtl/vector_loader_byte_packer.sv | 43 ++++
 rtl/vector_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/vector_loader_pkg.sv
// Shared defaults and FSM state type for the vector_loader byte-to-vector-pair feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional parity feature is selected with VECTOR_LOADER_PARITY_EN.
package vector_loader_pkg;

  localparam int DEF_VEC_W  = 32;
  localparam int DEF_BYTE_W = 8;
  localparam int DEF_BEATS  = DEF_VEC_W / DEF_BYTE_W;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    FULL   = 2'd2
  } vl_state_t;

endpackage

// File: rtl/vector_loader_if.sv
// Byte-stream input channel and vector-pair output channel of vector_loader.
// Latency: n/a (wires only).
// Backpressure: in_ready / out_ready; parity signals appear with VECTOR_LOADER_PARITY_EN.
interface vector_loader_if
  import vector_loader_pkg::*;
#(
  parameter int VEC_W  = DEF_VEC_W,
  parameter int BYTE_W = DEF_BYTE_W
) ();

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [VEC_W-1:0]  vector_a;
  logic [VEC_W-1:0]  vector_b;
  logic              out_valid;
  logic              out_ready;

`ifdef VECTOR_LOADER_PARITY_EN
  logic              in_parity;
  logic              par_err;

  modport master (
    output in_data, in_valid, in_parity, out_ready,
    input  in_ready, vector_a, vector_b, out_valid, par_err
  );

  modport slave (
    input  in_data, in_valid, in_parity, out_ready,
    output in_ready, vector_a, vector_b, out_valid, par_err
  );
`else
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, vector_a, vector_b, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, vector_a, vector_b, out_valid
  );
`endif

endinterface

// File: rtl/vector_loader_byte_packer.sv
// Little-endian staging register: writes one byte per load into lane idx, clear zeroes it.
// Latency: merged_o shows the incoming byte combinationally; the register updates next edge.
// Backpressure: none; the caller decides when to load.
module vector_loader_byte_packer #(
  parameter int BYTE_W = 8,
  parameter int BEATS  = 4,
  parameter int CNT_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr_i,
  input  logic                    load_i,
  input  logic [CNT_W-1:0]        idx_i,
  input  logic [BYTE_W-1:0]       data_i,
  output logic [BYTE_W*BEATS-1:0] merged_o
);

  logic [BYTE_W*BEATS-1:0] value_q;
  logic [BYTE_W*BEATS-1:0] value_d;

  // Staged value with the current byte already merged into its lane, so a
  // last-byte transfer can copy the complete vector in the same edge.
  always_comb begin
    value_d = value_q;
    if (load_i) begin
      value_d[int'(idx_i)*BYTE_W +: BYTE_W] = data_i;
    end
  end

  assign merged_o = value_d;

  // Staging register: clear wins so a consumed or dropped vector never lingers.
  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (clr_i) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/vector_loader.sv
// Packs a byte stream into vector_a then vector_b and presents the pair on a registered output.
// Latency: out_valid rises one cycle after the 8th byte is accepted when the output slot is free.
// Backpressure: in_ready drops only in FULL (pair staged, output held); optional VECTOR_LOADER_PARITY_EN.
module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int VEC_W  = DEF_VEC_W,
  parameter int BYTE_W = DEF_BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  vector_loader_if.slave    bus
);

  localparam int NBEATS = VEC_W / BYTE_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  vl_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [VEC_W-1:0] vec_a_q;
  logic [VEC_W-1:0] vec_b_q;
  logic             out_valid_q;

  logic             accept;
  logic             last_beat;
  logic             pair_done;
  logic             slot_free;
  logic             transfer;
  logic             drop;
  logic             load_a;
  logic             load_b;
  logic [VEC_W-1:0] pk_a;
  logic [VEC_W-1:0] pk_b;

  assign accept    = bus.in_valid && (state_q != FULL);
  assign last_beat = (cnt_q == LAST_BEAT);
  assign pair_done = accept && (state_q == LOAD_B) && last_beat;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign load_a    = accept && (state_q == LOAD_A);
  assign load_b    = accept && (state_q == LOAD_B);

  // A completed pair moves to the output either on its last byte or later from FULL.
  assign transfer  = ((pair_done && !drop) || (state_q == FULL)) && slot_free;

`ifdef VECTOR_LOADER_PARITY_EN
  logic bad_q;
  logic par_err_q;
  logic byte_bad;

  assign byte_bad = ^{bus.in_data, bus.in_parity};
  assign drop     = pair_done && (bad_q || byte_bad);

  // Track whether any byte of the pair in flight failed even parity; pulse the error on drop.
  always_ff @(posedge clk) begin
    if (reset) begin
      bad_q     <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= drop;
      if (pair_done) begin
        bad_q <= 1'b0;
      end else if (accept && byte_bad) begin
        bad_q <= 1'b1;
      end
    end
  end

  assign bus.par_err = par_err_q;
`else
  assign drop = 1'b0;
`endif

  vector_loader_byte_packer #(
    .BYTE_W (BYTE_W),
    .BEATS  (NBEATS),
    .CNT_W  (CNT_W)
  ) u_pack_a (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (transfer || drop),
    .load_i   (load_a),
    .idx_i    (cnt_q),
    .data_i   (bus.in_data),
    .merged_o (pk_a)
  );

  vector_loader_byte_packer #(
    .BYTE_W (BYTE_W),
    .BEATS  (NBEATS),
    .CNT_W  (CNT_W)
  ) u_pack_b (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (transfer || drop),
    .load_i   (load_b),
    .idx_i    (cnt_q),
    .data_i   (bus.in_data),
    .merged_o (pk_b)
  );

  // Load-state FSM with beat counter and registered output pair.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      vec_a_q     <= '0;
      vec_b_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
      end

      case (state_q)
        LOAD_A: if (accept && last_beat) state_q <= LOAD_B;
        LOAD_B: if (pair_done) state_q <= (drop || slot_free) ? LOAD_A : FULL;
        FULL:   if (slot_free) state_q <= LOAD_A;
        default: state_q <= LOAD_A;
      endcase

      if (transfer) begin
        vec_a_q     <= pk_a;
        vec_b_q     <= pk_b;
        out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = (state_q != FULL);
  assign bus.vector_a  = vec_a_q;
  assign bus.vector_b  = vec_b_q;
  assign bus.out_valid = out_valid_q;

endmodule
